// File: rtl/abc_scan_sequencer.sv
// abc_scan_sequencer: registered 3-bit {A,B,C} scan code generator for a 3-to-8 decoder.
// Steps up or down with a programmable dwell, in wrapping or one-shot mode, with load and stop.
module abc_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
  input  logic [2:0]         load_val,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               busy,
  output logic               step,
  output logic               wrap,
  output logic               done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_code, w_code_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_dir, r_one_shot;
  logic               r_step, r_wrap, r_done;
  logic               w_step_nxt, w_wrap_nxt, w_done_nxt;
  logic               w_start_ok, w_expire, w_terminal, w_running;

  assign w_start_ok = (r_state == ST_IDLE) && start && !stop;
  assign w_running  = (r_state == ST_RUN) && !stop && !load;
  assign w_expire   = (r_cnt == r_dwell);
  assign w_terminal = r_dir ? (r_code == 3'd0) : (r_code == 3'd7);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: stop dominates, a load keeps RUN alive, one-shot ends at terminal expiry.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start && !stop) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop)
          w_state_nxt = ST_IDLE;
        else if (!load && w_expire && r_one_shot && w_terminal)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next code, dwell count and strobes, all registered below.
  always_comb begin
    w_code_nxt = r_code;
    w_cnt_nxt  = r_cnt;
    w_step_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (load) begin
      w_code_nxt = load_val;
      w_cnt_nxt  = '0;
    end
    if (w_start_ok || ((r_state == ST_RUN) && stop)) begin
      w_cnt_nxt = '0;
    end else if (w_running) begin
      if (!w_expire) begin
        w_cnt_nxt = r_cnt + DWELL_W'(1);
      end else begin
        w_cnt_nxt = '0;
        if (r_one_shot && w_terminal) begin
          w_done_nxt = 1'b1;
        end else begin
          w_code_nxt = r_dir ? r_code - 3'd1 : r_code + 3'd1;
          w_step_nxt = 1'b1;
          w_wrap_nxt = w_terminal;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code     <= '0;
      r_cnt      <= '0;
      r_dwell    <= '0;
      r_dir      <= 1'b0;
      r_one_shot <= 1'b0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_code <= w_code_nxt;
      r_cnt  <= w_cnt_nxt;
      r_step <= w_step_nxt;
      r_wrap <= w_wrap_nxt;
      r_done <= w_done_nxt;
      if (w_start_ok) begin
        r_dwell    <= dwell;
        r_dir      <= dir;
        r_one_shot <= one_shot;
      end
    end
  end

  assign {A, B, C} = r_code;
  assign busy      = (r_state == ST_RUN);
  assign step      = r_step;
  assign wrap      = r_wrap;
  assign done      = r_done;

endmodule

// File: tb/tb_abc_scan_sequencer.sv
// Self-checking bench for abc_scan_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a countdown-based behavioural model of the scan rules.
module tb_abc_scan_sequencer;

  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0, stop = 1'b0, dir = 1'b0, one_shot = 1'b0, load = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [2:0]         load_val = '0;
  logic               A, B, C, busy, step, wrap, done;

  abc_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .one_shot(one_shot), .dwell(dwell), .load(load), .load_val(load_val),
    .A(A), .B(B), .C(C), .busy(busy), .step(step), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: m_left counts the cycles still to elapse before the next advance.
  int m_code, m_left, m_dwell;
  bit m_busy, m_dir, m_os, m_step, m_wrap, m_done;

  int n_step, n_wrap, n_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 0; m_left = 0; m_dwell = 0;
    m_busy = 0; m_dir = 0; m_os = 0;
    m_step = 0; m_wrap = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit was_busy;
    was_busy = m_busy;
    m_step = 0; m_wrap = 0; m_done = 0;
    if (was_busy && stop) m_busy = 0;
    if (load) begin
      m_code = int'(load_val);
      m_left = m_dwell + 1;
    end else if (was_busy && !stop) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_os && m_code == (m_dir ? 0 : 7)) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_code = (m_code + (m_dir ? 7 : 1)) % 8;
          m_step = 1;
          m_wrap = (m_code == (m_dir ? 7 : 0));
          m_left = m_dwell + 1;
        end
      end
    end
    if (!was_busy && start && !stop) begin
      m_busy  = 1;
      m_dir   = dir;
      m_os    = one_shot;
      m_dwell = int'(dwell);
      m_left  = m_dwell + 1;
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({A, B, C, busy, step, wrap, done});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({3'(m_code), m_busy, m_step, m_wrap, m_done});
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, dut_vec(), model_vec());
    n_step += int'(step);
    n_wrap += int'(wrap);
    n_done += int'(done);
  endtask

  task automatic cyc(input string tag, input bit s, input bit p, input bit l, input logic [2:0] lv);
    start = s; stop = p; load = l; load_val = lv;
    tick(tag);
    start = 0; stop = 0; load = 0;
  endtask

  task automatic clear_counts();
    n_step = 0; n_wrap = 0; n_done = 0;
  endtask

  initial begin
    model_reset();
    clear_counts();
    #2;
    check("reset_outputs", dut_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1;
    tick("idle_after_reset");

    // Continuous up scan, dwell=2: nine advances 0..7,0,1 in 27 cycles, one wrap.
    dir = 0; one_shot = 0; dwell = 8'd2;
    clear_counts();
    cyc("cont_up_start", 1, 0, 0, 3'd0);
    for (int i = 0; i < 27; i++) tick("cont_up");
    check("cont_up_steps", 32'(n_step), 32'd9);
    check("cont_up_wraps", 32'(n_wrap), 32'd1);
    check("cont_up_code", 32'({A, B, C}), 32'd1);
    check("cont_up_busy", 32'(busy), 32'd1);
    cyc("stop1", 0, 1, 0, 3'd0);

    // One-shot down from 5 with dwell=0: five steps, done once, no wrap.
    cyc("load5", 0, 0, 1, 3'd5);
    dir = 1; one_shot = 1; dwell = 8'd0;
    clear_counts();
    cyc("os_down_start", 1, 0, 0, 3'd0);
    for (int i = 0; i < 8; i++) tick("os_down");
    check("os_down_steps", 32'(n_step), 32'd5);
    check("os_down_wraps", 32'(n_wrap), 32'd0);
    check("os_down_dones", 32'(n_done), 32'd1);
    check("os_down_code", 32'({A, B, C}), 32'd0);

    // Stop mid-dwell at code 2, later resume with a full dwell.
    cyc("load2", 0, 0, 1, 3'd2);
    dir = 0; one_shot = 0; dwell = 8'd3;
    cyc("stop_test_start", 1, 0, 0, 3'd0);
    tick("stop_test_run");
    clear_counts();
    cyc("stop_mid", 0, 1, 0, 3'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_code", 32'({A, B, C}), 32'd2);
    for (int i = 0; i < 3; i++) tick("stop_idle");
    check("stop_no_strobes", 32'(n_step + n_wrap + n_done), 32'd0);
    cyc("resume_start", 1, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++) tick("resume_hold");
    check("resume_held", 32'({A, B, C}), 32'd2);
    tick("resume_adv");
    check("resume_code", 32'({A, B, C}), 32'd3);

    // Load on the dwell-expiry edge: load wins, no step, full period afterwards.
    for (int i = 0; i < 3; i++) tick("pre_load_dwell");
    clear_counts();
    cyc("load_on_expiry", 0, 0, 1, 3'd6);
    check("load_expiry_code", 32'({A, B, C}), 32'd6);
    check("load_expiry_nostep", 32'(n_step), 32'd0);
    for (int i = 0; i < 4; i++) tick("after_load");
    check("after_load_code", 32'({A, B, C}), 32'd7);

    // Start+stop in IDLE stays idle; dir change during RUN has no effect.
    cyc("stop2", 0, 1, 0, 3'd0);
    cyc("start_stop_idle", 1, 1, 0, 3'd0);
    check("start_stop_busy", 32'(busy), 32'd0);
    dir = 0; dwell = 8'd1;
    cyc("dir_test_start", 1, 0, 0, 3'd0);
    dir = 1;
    for (int i = 0; i < 6; i++) tick("dir_change");
    check("dir_change_code", 32'({A, B, C}), 32'd2);

    // Asynchronous reset mid-scan.
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) tick("post_reset_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      dir      = 1'($urandom_range(0, 1));
      one_shot = 1'($urandom_range(0, 1));
      dwell    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3));
      cyc("random", $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 14) == 0, 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
